// File: rtl/bp_me_dram_stream_bridge.sv
// Bridge between the BedRock-style DRAM message stream and a simple
// one-word-per-request DRAM port.  Writes stream command beats straight
// to DRAM; reads issue one DRAM word request at a time and forward each
// returned word as a response data beat.
// Optional feature macro: BP_ME_DRAM_BRIDGE_WRAP_EN selects
// critical-word-first wrapped beat addressing (default: linear from the
// size-aligned block base).
//
// Header layout (LSB first): msg_type[3:0], addr[paddr], size[2:0]
// (log2 bytes), payload[15:0].

package bp_me_dram_stream_bridge_pkg;

    typedef enum int {
        e_bp_default_cfg    = 0,
        e_bp_wide_paddr_cfg = 1
    } bp_params_e;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3,
        e_mem_msg_pre   = 4'd4,
        e_mem_msg_amo   = 4'd5
    } bp_mem_msg_e;

    localparam int mem_payload_width_gp = 16;

endpackage

module bp_me_dram_stream_bridge
    import bp_me_dram_stream_bridge_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int dram_addr_width_p        = 28,
    localparam int paddr_width_p           = (bp_params_p == e_bp_default_cfg) ? 40 : 56,
    localparam int dword_width_p           = 64,
    localparam int dram_mem_msg_header_width_lp = 4 + paddr_width_p + 3 + mem_payload_width_gp
)(
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,

    input  logic [dram_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
    input  logic                                    mem_cmd_header_v_i,
    output logic                                    mem_cmd_header_yumi_o,

    input  logic [dword_width_p-1:0]                mem_cmd_data_i,
    input  logic                                    mem_cmd_data_v_i,
    output logic                                    mem_cmd_data_yumi_o,

    output logic [dram_mem_msg_header_width_lp-1:0] mem_resp_header_o,
    output logic                                    mem_resp_header_v_o,
    input  logic                                    mem_resp_header_ready_i,

    output logic [dword_width_p-1:0]                mem_resp_data_o,
    output logic                                    mem_resp_data_v_o,
    input  logic                                    mem_resp_data_ready_i,

    output logic                                    dram_v_o,
    output logic                                    dram_w_o,
    output logic [dram_addr_width_p-1:0]            dram_addr_o,
    output logic [dword_width_p-1:0]                dram_data_o,
    input  logic                                    dram_ready_i,

    input  logic [dword_width_p-1:0]                dram_data_i,
    input  logic                                    dram_data_v_i
);

    localparam int addr_lsb_lp = 4;
    localparam int size_lsb_lp = 4 + paddr_width_p;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RESP, RD_RESP, RD_REQ, RD_WAIT, RD_DATA
    } state_e;

    state_e                                  r_state, w_state_nxt;
    logic                                    r_run;
    logic [dram_mem_msg_header_width_lp-1:0] r_hdr;
    logic [3:0]                              r_cnt;
    logic [dword_width_p-1:0]                r_data;

    logic                                    w_hdr_acc, w_cnt_inc, w_capture;
    logic [3:0]                              w_beats_m1, w_low;
    logic                                    w_last, w_no_data;
    logic [dram_addr_width_p-1:0]            w_word, w_mask;

    // Sizes up to one dword take a single beat; larger sizes take size/8 beats.
    function automatic logic [3:0] beats_m1_f(input logic [2:0] size);
        case (size)
            3'd4:    return 4'd1;
            3'd5:    return 4'd3;
            3'd6:    return 4'd7;
            3'd7:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic is_wr_f(input logic [3:0] t);
        return (t == e_mem_msg_wr) || (t == e_mem_msg_uc_wr);
    endfunction

    function automatic logic is_rd_f(input logic [3:0] t);
        return (t == e_mem_msg_rd) || (t == e_mem_msg_uc_rd);
    endfunction

    assign w_beats_m1 = beats_m1_f(r_hdr[size_lsb_lp +: 3]);
    assign w_last     = (r_cnt == w_beats_m1);
    assign w_no_data  = !(is_rd_f(r_hdr[3:0]) || is_wr_f(r_hdr[3:0]));

    // Beat address: dword address of the header, block base from the size
    // mask, low bits from the beat counter (optionally rotated by the offset).
    assign w_word = r_hdr[addr_lsb_lp + 3 +: dram_addr_width_p];
    assign w_mask = {{(dram_addr_width_p-4){1'b0}}, w_beats_m1};
`ifdef BP_ME_DRAM_BRIDGE_WRAP_EN
    assign w_low  = (w_word[3:0] + r_cnt) & w_beats_m1;
`else
    assign w_low  = r_cnt & w_beats_m1;
`endif
    assign dram_addr_o = (w_word & ~w_mask) | {{(dram_addr_width_p-4){1'b0}}, w_low};

    assign mem_resp_header_o = r_hdr;
    assign mem_resp_data_o   = r_data;

    // Next-state and handshake outputs; everything idles low by default.
    always_comb begin
        w_state_nxt           = r_state;
        w_hdr_acc             = 1'b0;
        w_cnt_inc             = 1'b0;
        w_capture             = 1'b0;
        mem_cmd_header_yumi_o = 1'b0;
        mem_cmd_data_yumi_o   = 1'b0;
        mem_resp_header_v_o   = 1'b0;
        mem_resp_data_v_o     = 1'b0;
        dram_v_o              = 1'b0;
        dram_w_o              = 1'b0;
        dram_data_o           = '0;
        case (r_state)
            IDLE: begin
                mem_cmd_header_yumi_o = r_run & mem_cmd_header_v_i;
                if (mem_cmd_header_yumi_o) begin
                    w_hdr_acc   = 1'b1;
                    w_state_nxt = is_wr_f(mem_cmd_header_i[3:0]) ? WR_DATA : RD_RESP;
                end
            end
            WR_DATA: begin
                dram_v_o            = mem_cmd_data_v_i;
                dram_w_o            = 1'b1;
                dram_data_o         = mem_cmd_data_i;
                mem_cmd_data_yumi_o = mem_cmd_data_v_i & dram_ready_i;
                if (mem_cmd_data_yumi_o) begin
                    if (w_last) w_state_nxt = WR_RESP;
                    else        w_cnt_inc   = 1'b1;
                end
            end
            WR_RESP: begin
                mem_resp_header_v_o = 1'b1;
                if (mem_resp_header_ready_i) w_state_nxt = IDLE;
            end
            RD_RESP: begin
                mem_resp_header_v_o = 1'b1;
                if (mem_resp_header_ready_i) w_state_nxt = w_no_data ? IDLE : RD_REQ;
            end
            RD_REQ: begin
                dram_v_o = 1'b1;
                if (dram_ready_i) w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (dram_data_v_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                mem_resp_data_v_o = 1'b1;
                if (mem_resp_data_ready_i) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = RD_REQ;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; r_run keeps header acceptance off while reset is held.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Command header capture and beat counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr <= '0;
            r_cnt <= 4'd0;
        end else if (w_hdr_acc) begin
            r_hdr <= mem_cmd_header_i;
            r_cnt <= 4'd0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Read return capture; only taken while waiting on an issued request.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data <= '0;
        end else if (w_capture) begin
            r_data <= dram_data_i;
        end
    end

endmodule

// File: tb/tb_bp_me_dram_stream_bridge.sv
// Directed bench for bp_me_dram_stream_bridge: write streaming, reads with
// DRAM latency, wrap addressing, zero-beat messages, backpressure and reset.
module tb_bp_me_dram_stream_bridge;
    import bp_me_dram_stream_bridge_pkg::*;

    localparam int HW = 63;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n_i;
    logic [HW-1:0] mem_cmd_header_i;
    logic          mem_cmd_header_v_i, mem_cmd_header_yumi_o;
    logic [63:0]   mem_cmd_data_i;
    logic          mem_cmd_data_v_i, mem_cmd_data_yumi_o;
    logic [HW-1:0] mem_resp_header_o;
    logic          mem_resp_header_v_o, mem_resp_header_ready_i;
    logic [63:0]   mem_resp_data_o;
    logic          mem_resp_data_v_o, mem_resp_data_ready_i;
    logic          dram_v_o, dram_w_o, dram_ready_i;
    logic [27:0]   dram_addr_o;
    logic [63:0]   dram_data_o, dram_data_i;
    logic          dram_data_v_i;

    logic          rdy_main, bp_mode, bp_tog;
    int            bp_c = 0;
    logic          model_v, stray_v;
    logic [63:0]   model_d;

    assign mem_resp_data_ready_i = bp_mode ? bp_tog : rdy_main;
    assign dram_data_v_i         = model_v | stray_v;
    assign dram_data_i           = stray_v ? 64'hDEAD_BEEF_0BAD_F00D : model_d;

    bp_me_dram_stream_bridge #(.dram_addr_width_p(28)) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n_i),
        .mem_cmd_header_i       (mem_cmd_header_i),
        .mem_cmd_header_v_i     (mem_cmd_header_v_i),
        .mem_cmd_header_yumi_o  (mem_cmd_header_yumi_o),
        .mem_cmd_data_i         (mem_cmd_data_i),
        .mem_cmd_data_v_i       (mem_cmd_data_v_i),
        .mem_cmd_data_yumi_o    (mem_cmd_data_yumi_o),
        .mem_resp_header_o      (mem_resp_header_o),
        .mem_resp_header_v_o    (mem_resp_header_v_o),
        .mem_resp_header_ready_i(mem_resp_header_ready_i),
        .mem_resp_data_o        (mem_resp_data_o),
        .mem_resp_data_v_o      (mem_resp_data_v_o),
        .mem_resp_data_ready_i  (mem_resp_data_ready_i),
        .dram_v_o               (dram_v_o),
        .dram_w_o               (dram_w_o),
        .dram_addr_o            (dram_addr_o),
        .dram_data_o            (dram_data_o),
        .dram_ready_i           (dram_ready_i),
        .dram_data_i            (dram_data_i),
        .dram_data_v_i          (dram_data_v_i)
    );

    int            n_chk = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [39:0] a,
                                             input logic [2:0] s, input logic [15:0] p);
        return {p, s, a, t};
    endfunction

    function automatic logic [63:0] dram_word(input logic [27:0] a);
        return {36'hA5A5A5A5A, a};
    endfunction

    // DRAM stub: one return per read grant after rd_lat cycles, plus logs.
    int            rd_lat = 3;
    int            cnt_m = 0;
    int            grants = 0;
    int            overlap = 0;
    logic [27:0]   pend_addr;
    logic [27:0]   rd_addr_q[$];
    logic [63:0]   rd_data_q[$];
    logic [27:0]   wr_addr_q[$];
    logic [63:0]   wr_data_q[$];
    logic [HW-1:0] hdr_q[$];

    always @(negedge clk) begin
        model_v = 1'b0;
        if (!reset_n_i) begin
            cnt_m = 0;
        end else begin
            if (cnt_m > 0) begin
                cnt_m--;
                if (cnt_m == 0) begin
                    model_v = 1'b1;
                    model_d = dram_word(pend_addr);
                end
            end
            if (dram_v_o && dram_ready_i && !dram_w_o) begin
                if (cnt_m != 0) overlap++;
                cnt_m     = rd_lat;
                pend_addr = dram_addr_o;
                grants++;
                rd_addr_q.push_back(dram_addr_o);
            end
            if (dram_v_o && dram_ready_i && dram_w_o) begin
                wr_addr_q.push_back(dram_addr_o);
                wr_data_q.push_back(dram_data_o);
            end
            if (mem_resp_data_v_o && mem_resp_data_ready_i) rd_data_q.push_back(mem_resp_data_o);
            if (mem_resp_header_v_o && mem_resp_header_ready_i) hdr_q.push_back(mem_resp_header_o);
        end
    end

    // Stall stability: anything valid and not taken must hold next cycle.
    int            stab_err = 0;
    logic          p_dv = 1'b0, p_rv = 1'b0, p_hv = 1'b0;
    logic [27:0]   p_da;
    logic [63:0]   p_rd;
    logic [HW-1:0] p_ho;

    always @(negedge clk) begin
        if (!reset_n_i) begin
            p_dv = 1'b0; p_rv = 1'b0; p_hv = 1'b0;
        end else begin
            if (p_dv && (!dram_v_o || dram_addr_o !== p_da)) stab_err++;
            if (p_rv && (!mem_resp_data_v_o || mem_resp_data_o !== p_rd)) stab_err++;
            if (p_hv && (!mem_resp_header_v_o || mem_resp_header_o !== p_ho)) stab_err++;
            p_dv = dram_v_o && !dram_ready_i;          p_da = dram_addr_o;
            p_rv = mem_resp_data_v_o && !mem_resp_data_ready_i; p_rd = mem_resp_data_o;
            p_hv = mem_resp_header_v_o && !mem_resp_header_ready_i; p_ho = mem_resp_header_o;
        end
    end

    // 1-in-3 response data ready pattern for the backpressure case.
    always @(posedge clk) begin
        #1;
        bp_c   = bp_c + 1;
        bp_tog = (bp_c % 3 == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [HW-1:0] h);
        int k = 0;
        mem_cmd_header_i   = h;
        mem_cmd_header_v_i = 1'b1;
        do begin @(negedge clk); k++; end while (!mem_cmd_header_yumi_o && k < 200);
        chk("hdr_accept", mem_cmd_header_yumi_o, 1'b1);
        tick();
        mem_cmd_header_v_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit chk_busy);
        int k = 0;
        mem_cmd_data_i   = d;
        mem_cmd_data_v_i = 1'b1;
        do begin @(negedge clk); k++; end while (!mem_cmd_data_yumi_o && k < 200);
        chk("wr_beat_accept", mem_cmd_data_yumi_o, 1'b1);
        if (chk_busy) chk("wr_busy_hdr_yumi", mem_cmd_header_yumi_o, 1'b0);
        tick();
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (rd_data_q.size() < n && k < 3000) begin @(negedge clk); k++; end
        chk("rd_beat_count", rd_data_q.size(), n);
        tick();
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); rd_data_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); hdr_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HW-1:0] h_wr, h_rd, h;
        logic [27:0]   exp_a[8];
        int            g0, s0, sz0, k;

        reset_n_i = 1'b0;
        mem_cmd_header_i = mk_hdr(4'd1, 40'h0, 3'd6, 16'h0); mem_cmd_header_v_i = 1'b1;
        mem_cmd_data_i = '0; mem_cmd_data_v_i = 1'b0;
        mem_resp_header_ready_i = 1'b1; rdy_main = 1'b1; bp_mode = 1'b0;
        dram_ready_i = 1'b1; stray_v = 1'b0;
        repeat (3) tick();
        chk("rst_hdr_yumi", mem_cmd_header_yumi_o, 1'b0);
        chk("rst_dram_v", dram_v_o, 1'b0);
        chk("rst_dram_w", dram_w_o, 1'b0);
        chk("rst_resp_hdr_v", mem_resp_header_v_o, 1'b0);
        chk("rst_resp_data_v", mem_resp_data_v_o, 1'b0);
        chk("rst_data_yumi", mem_cmd_data_yumi_o, 1'b0);
        chk("rst_resp_hdr", mem_resp_header_o, '0);
        chk("rst_resp_data", mem_resp_data_o, 64'h0);
        mem_cmd_header_v_i = 1'b0;
        reset_n_i = 1'b1;
        tick();

        // 64 B write to 0x8000_0040, read header queued behind it.
        h_wr = mk_hdr(4'd1, 40'h00_8000_0040, 3'd6, 16'h0031);
        h_rd = mk_hdr(4'd0, 40'h00_0000_0040, 3'd6, 16'h0032);
        clear_logs(); g0 = grants; rd_lat = 3;
        send_hdr(h_wr);
        mem_cmd_header_i = h_rd; mem_cmd_header_v_i = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(64'h1111_0000_0000_0000 + 64'(i), i == 0);
        mem_cmd_data_v_i = 1'b0;
        @(negedge clk);
        chk("wr_resp_hdr_v", mem_resp_header_v_o, 1'b1);
        chk("wr_resp_hdr", mem_resp_header_o, h_wr);
        chk("wr_resp_hdr_yumi_blocked", mem_cmd_header_yumi_o, 1'b0);
        tick();
        @(negedge clk);
        chk("b2b_hdr_yumi", mem_cmd_header_yumi_o, 1'b1);
        tick();
        mem_cmd_header_v_i = 1'b0;
        chk("wr_count", wr_addr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("wr_addr", wr_addr_q[i], 28'h8 + 28'(i));
            chk("wr_data", wr_data_q[i], 64'h1111_0000_0000_0000 + 64'(i));
        end

        // 64 B read of 0x40, DRAM latency 3.
        @(negedge clk);
        chk("rd_resp_hdr_v", mem_resp_header_v_o, 1'b1);
        chk("rd_resp_hdr", mem_resp_header_o, h_rd);
        wait_rd(8);
        for (int i = 0; i < 8; i++) begin
            chk("rd_addr", rd_addr_q[i], 28'h8 + 28'(i));
            chk("rd_data", rd_data_q[i], dram_word(28'h8 + 28'(i)));
        end
        chk("rd_grants", grants - g0, 8);
        chk("rd_overlap", overlap, 0);
        chk("rd_hdr_q0", hdr_q[0], h_wr);
        chk("rd_hdr_q1", hdr_q[1], h_rd);

        // Read of 0x58: wrapped or linear beat order.
`ifdef BP_ME_DRAM_BRIDGE_WRAP_EN
        exp_a = '{28'hB, 28'hC, 28'hD, 28'hE, 28'hF, 28'h8, 28'h9, 28'hA};
`else
        exp_a = '{28'h8, 28'h9, 28'hA, 28'hB, 28'hC, 28'hD, 28'hE, 28'hF};
`endif
        clear_logs(); rd_lat = 1;
        send_hdr(mk_hdr(4'd0, 40'h58, 3'd6, 16'h0033));
        wait_rd(8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_addr", rd_addr_q[i], exp_a[i]);
            chk("wrap_data", rd_data_q[i], dram_word(exp_a[i]));
        end

        // Unsupported type: header only, no DRAM traffic.
        h = mk_hdr(4'd4, 40'h100, 3'd6, 16'h0034);
        g0 = grants;
        send_hdr(h);
        @(negedge clk);
        chk("zb_resp_hdr_v", mem_resp_header_v_o, 1'b1);
        chk("zb_resp_hdr", mem_resp_header_o, h);
        tick();
        @(negedge clk);
        chk("zb_idle_hdr_v", mem_resp_header_v_o, 1'b0);
        chk("zb_idle_dram_v", dram_v_o, 1'b0);
        repeat (3) tick();
        chk("zb_grants", grants - g0, 0);

        // Backpressure: DRAM grant held off 5 cycles, data ready 1-in-3.
        clear_logs(); rd_lat = 2; g0 = grants; s0 = stab_err;
        dram_ready_i = 1'b0; bp_mode = 1'b1;
        send_hdr(mk_hdr(4'd2, 40'h80, 3'd6, 16'h0035));
        repeat (5) tick();
        @(negedge clk);
        chk("bp_dram_v_held", dram_v_o, 1'b1);
        chk("bp_dram_addr_held", dram_addr_o, 28'h10);
        chk("bp_no_grant", grants - g0, 0);
        tick();
        dram_ready_i = 1'b1;
        wait_rd(8);
        for (int i = 0; i < 8; i++) chk("bp_data", rd_data_q[i], dram_word(28'h10 + 28'(i)));
        chk("bp_grants", grants - g0, 8);
        chk("bp_stable", stab_err - s0, 0);
        chk("bp_overlap", overlap, 0);
        bp_mode = 1'b0;

        // Reset during beat 4 of a read, stray return, then a write.
        clear_logs(); rd_lat = 3; g0 = grants;
        send_hdr(mk_hdr(4'd0, 40'h40, 3'd6, 16'h0036));
        k = 0;
        while ((grants - g0) < 4 && k < 500) begin @(negedge clk); k++; end
        chk("rst_reach_beat4", grants - g0, 4);
        @(posedge clk);
        #2;
        reset_n_i = 1'b0;
        mem_cmd_header_v_i = 1'b1;
        #1;
        chk("mid_rst_dram_v", dram_v_o, 1'b0);
        chk("mid_rst_resp_data_v", mem_resp_data_v_o, 1'b0);
        chk("mid_rst_resp_hdr_v", mem_resp_header_v_o, 1'b0);
        chk("mid_rst_hdr_yumi", mem_cmd_header_yumi_o, 1'b0);
        chk("mid_rst_resp_data", mem_resp_data_o, 64'h0);
        chk("mid_rst_resp_hdr", mem_resp_header_o, '0);
        mem_cmd_header_v_i = 1'b0;
        sz0 = rd_data_q.size();
        repeat (2) tick();
        reset_n_i = 1'b1;
        tick();
        stray_v = 1'b1;
        tick();
        stray_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_resp_data_v", mem_resp_data_v_o, 1'b0);
        chk("stray_resp_data", mem_resp_data_o, 64'h0);
        chk("stray_dram_v", dram_v_o, 1'b0);
        chk("stray_no_beats", rd_data_q.size(), sz0);
        tick();

        h = mk_hdr(4'd3, 40'h1238, 3'd3, 16'h0037);
        clear_logs();
        send_hdr(h);
        send_beat(64'h0123_4567_89AB_CDEF, 1'b0);
        mem_cmd_data_v_i = 1'b0;
        @(negedge clk);
        chk("post_rst_resp_hdr_v", mem_resp_header_v_o, 1'b1);
        chk("post_rst_resp_hdr", mem_resp_header_o, h);
        tick();
        chk("post_rst_wr_count", wr_addr_q.size(), 1);
        chk("post_rst_wr_addr", wr_addr_q[0], 28'h247);
        chk("post_rst_wr_data", wr_data_q[0], 64'h0123_4567_89AB_CDEF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_me_dram_stream_bridge.md
BP_ME_DRAM_STREAM_BRIDGE -- requirements
Module: bp_me_dram_stream_bridge

Interface
REQ-001 The block SHALL have parameter bp_params_p, default e_bp_default_cfg: source of paddr_width_p, dword_width_p (64) and dram_mem_msg_header_width_lp.
REQ-002 The block SHALL have parameter dram_addr_width_p, default 28: dword-granular DRAM address width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports mem_cmd_header_i (input, header width), mem_cmd_header_v_i (input, 1) and mem_cmd_header_yumi_o (output, 1): the DRAM command header stream.
REQ-006 The block SHALL have ports mem_cmd_data_i (input, 64), mem_cmd_data_v_i (input, 1) and mem_cmd_data_yumi_o (output, 1): write data beats.
REQ-007 The block SHALL have ports mem_resp_header_o (output, header width), mem_resp_header_v_o (output, 1) and mem_resp_header_ready_i (input, 1): the response header.
REQ-008 The block SHALL have ports mem_resp_data_o (output, 64), mem_resp_data_v_o (output, 1) and mem_resp_data_ready_i (input, 1): read data beats.
REQ-009 The block SHALL have ports dram_v_o (output, 1), dram_w_o (output, 1), dram_addr_o (output, dram_addr_width_p), dram_data_o (output, 64) and dram_ready_i (input, 1): the DRAM word request port.
REQ-010 The block SHALL have ports dram_data_i (input, 64) and dram_data_v_i (input, 1): DRAM read return, one word per request, in order, any latency of 1 or more cycles.

Function
REQ-011 The FSM SHALL have states IDLE, WR_DATA, WR_RESP, RD_RESP, RD_REQ, RD_WAIT and RD_DATA.
REQ-012 mem_cmd_header_yumi_o SHALL equal (state==IDLE & mem_cmd_header_v_i); the accepted header SHALL be registered.
REQ-013 Decode: e_mem_msg_rd or e_mem_msg_uc_rd SHALL go to RD_RESP; e_mem_msg_wr or e_mem_msg_uc_wr SHALL go to WR_DATA; any other type SHALL go to RD_RESP with zero beats.
REQ-014 Beats SHALL be max(1, (1<<size)/8), giving 1..16 beats for sizes 8..128 B; the beat counter SHALL be 4 bits and SHALL clear on header accept.
REQ-015 dram_addr_o SHALL be the beat address [3 +: dram_addr_width_p]; higher address bits SHALL be dropped.
REQ-016 In WR_DATA: dram_v_o = mem_cmd_data_v_i, dram_w_o=1, dram_data_o = mem_cmd_data_i; mem_cmd_data_yumi_o = dram_v_o & dram_ready_i.
REQ-017 On the last write beat the FSM SHALL go to WR_RESP.
REQ-018 In WR_RESP and RD_RESP, mem_resp_header_v_o SHALL be 1 with header equal to the registered command header; on ready, WR_RESP SHALL go to IDLE, and RD_RESP SHALL go to RD_REQ, or to IDLE when there are zero beats.
REQ-019 RD_REQ SHALL drive dram_v_o=1, dram_w_o=0 and go to RD_WAIT on dram_ready_i.
REQ-020 RD_WAIT SHALL capture dram_data_i on dram_data_v_i into the data register and go to RD_DATA.
REQ-021 RD_DATA SHALL drive mem_resp_data_v_o=1 from the register; on ready it SHALL go to IDLE if it is the last beat, else to RD_REQ.
REQ-022 At most one DRAM read SHALL be outstanding; resp header and data valid SHALL be held stable until accepted.
REQ-023 Read latency from header yumi: resp header valid the next cycle; first data valid 2 cycles after the dram_ready_i grant plus DRAM latency.
REQ-024 dram_data_v_i outside RD_WAIT SHALL be ignored.
REQ-025 dram_v_o, mem_cmd_data_yumi_o and mem_resp_*_v_o SHALL be 0 in IDLE.
REQ-026 A new header arriving during an active transaction SHALL not be acknowledged; it is accepted back-to-back in the cycle after return to IDLE.

Reset
REQ-027 Asserting reset_n_i low SHALL asynchronously force: state IDLE, counter 0, header and data registers 0, all valid/yumi outputs 0, dram_w_o 0.
REQ-028 Reset mid-transaction SHALL abandon it with no response; a late dram_data_v_i after deassertion SHALL be ignored.

Configuration
REQ-029 With BP_ME_DRAM_BRIDGE_WRAP_EN defined, beat i SHALL address block_base + ((offset_word + i) mod beats) (critical-word-first wrap), where block_base is the header addr aligned to the message size.
REQ-030 Without BP_ME_DRAM_BRIDGE_WRAP_EN, beat i SHALL address block_base + i, with the low offset ignored.

Verification
REQ-031 64 B write to addr 0x8000_0040, 8 beats 0..7 with dram_ready_i=1 -> 8 DRAM writes to addresses 0x8..0xF; resp header equals cmd header, 1 cycle after the last beat.
REQ-032 64 B read of addr 0x40 with DRAM latency 3 -> resp header, then 8 data beats in address order 0x8..0xF, with no second read issued before the prior return.
REQ-033 Read of addr 0x58 with WRAP_EN -> DRAM addresses 0xB,0xC..0xF,0x8..0xA; without WRAP_EN -> 0x8..0xF.
REQ-034 Backpressure: mem_resp_data_ready_i toggling 1-in-3 and dram_ready_i held low for 5 cycles -> no data loss, outputs stable while stalled, no extra DRAM requests.
REQ-035 reset_n_i low during beat 4 of a read -> outputs 0 immediately; a stray dram_data_v_i is ignored; the next write completes correctly.
